// File: rtl/tree_loader.sv
// rtl/tree_loader.sv - Loads a game tree into the evaluator tables, starts it and returns the result
module tree_loader #(
  parameter int W_ADDR   = 10,
  parameter int W_N_DATA = 10,
  parameter int W_C_DATA = 10,
  parameter int W_ACTION = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [W_C_DATA-1:0] cfg_count,
  input  logic                nd_valid,
  output logic                nd_ready,
  input  logic [W_ADDR-1:0]   nd_parent,
  input  logic [W_N_DATA-1:0] nd_reward,
  input  logic                nd_strat,
  input  logic [W_ACTION-1:0] nd_action,
  input  logic [W_N_DATA-1:0] nd_weight,
  output logic                conf_nodes,
  output logic [W_C_DATA-1:0] conf_data,
  output logic                mem_par,
  output logic                mem_rew,
  output logic                mem_act,
  output logic                mem_weight,
  output logic [W_ADDR-1:0]   mem_addr,
  output logic [W_N_DATA-1:0] mem_data,
  output logic                eval_start,
  input  logic                exp_change,
  input  logic [W_N_DATA-1:0] exp,
  input  logic [W_ACTION-1:0] act,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W_N_DATA-1:0] res_exp,
  output logic [W_ACTION-1:0] res_act,
  output logic                res_timeout,
  output logic                busy
);

  localparam int W_CNT = $clog2(TIMEOUT) + 1;
  localparam logic [W_C_DATA-1:0] C_ONE      = W_C_DATA'(1);
  localparam logic [W_CNT-1:0]    C_CNT_ONE  = W_CNT'(1);
  localparam logic [W_CNT-1:0]    C_CNT_LAST = W_CNT'(TIMEOUT - 1);
  localparam logic [W_ADDR-1:0]   C_A_ONE    = W_ADDR'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_CONF, S_WAIT_NODE, S_W_PAR, S_W_REW, S_W_ACT, S_W_WGT, S_START, S_EVAL, S_RESULT
  } state_t;

  state_t                r_state;
  logic [W_C_DATA-1:0]   r_count;
  logic [W_ADDR-1:0]     r_idx;
  logic [W_CNT-1:0]      r_cnt;
  logic [W_ADDR-1:0]     r_parent;
  logic [W_N_DATA-1:0]   r_reward;
  logic                  r_strat;
  logic [W_ACTION-1:0]   r_action;
  logic [W_N_DATA-1:0]   r_weight;

  logic                  w_last;
  logic [W_CNT-1:0]      w_cnt_next;
  logic [W_N_DATA-1:0]   w_act_data;
  logic [W_N_DATA-1:0]   w_par_data;

  // Node index compare, evaluation counter increment and table word packing
  always_comb begin
    w_last     = (W_C_DATA'(r_idx) == (r_count - C_ONE));
    w_cnt_next = r_cnt + C_CNT_ONE;
    w_act_data = W_N_DATA'({r_strat, r_action});
    w_par_data = W_N_DATA'(r_parent);
  end

  // Control FSM; every output is registered and set on entry to the state that owns it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_parent    <= '0;
      r_reward    <= '0;
      r_strat     <= 1'b0;
      r_action    <= '0;
      r_weight    <= '0;
      cfg_ready   <= 1'b1;
      nd_ready    <= 1'b0;
      busy        <= 1'b0;
      conf_nodes  <= 1'b0;
      conf_data   <= '0;
      mem_par     <= 1'b0;
      mem_rew     <= 1'b0;
      mem_act     <= 1'b0;
      mem_weight  <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      eval_start  <= 1'b0;
      res_valid   <= 1'b0;
      res_exp     <= '0;
      res_act     <= '0;
      res_timeout <= 1'b0;
    end else begin
      // Strobes are single-cycle; the write bus returns to zero unless a state drives it
      conf_nodes <= 1'b0;
      conf_data  <= '0;
      mem_par    <= 1'b0;
      mem_rew    <= 1'b0;
      mem_act    <= 1'b0;
      mem_weight <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      eval_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A zero count is consumed without leaving IDLE
          if (cfg_valid && (cfg_count != '0)) begin
            r_count    <= cfg_count;
            r_idx      <= '0;
            r_state    <= S_CONF;
            cfg_ready  <= 1'b0;
            busy       <= 1'b1;
            conf_nodes <= 1'b1;
            conf_data  <= cfg_count;
          end
        end
        S_CONF: begin
          r_state  <= S_WAIT_NODE;
          nd_ready <= 1'b1;
        end
        S_WAIT_NODE: begin
          if (nd_valid) begin
            r_parent <= nd_parent;
            r_reward <= nd_reward;
            r_strat  <= nd_strat;
            r_action <= nd_action;
            r_weight <= nd_weight;
            nd_ready <= 1'b0;
            mem_addr <= r_idx;
            // The root has no parent entry
            if (r_idx != '0) begin
              r_state  <= S_W_PAR;
              mem_par  <= 1'b1;
              mem_data <= W_N_DATA'(nd_parent);
            end else begin
              r_state  <= S_W_REW;
              mem_rew  <= 1'b1;
              mem_data <= nd_reward;
            end
          end
        end
        S_W_PAR: begin
          r_state  <= S_W_REW;
          mem_rew  <= 1'b1;
          mem_addr <= r_idx;
          mem_data <= r_reward;
        end
        S_W_REW: begin
          r_state  <= S_W_ACT;
          mem_act  <= 1'b1;
          mem_addr <= r_idx;
          mem_data <= w_act_data;
        end
        S_W_ACT: begin
          r_state    <= S_W_WGT;
          mem_weight <= 1'b1;
          mem_addr   <= r_idx;
          mem_data   <= r_weight;
        end
        S_W_WGT: begin
          if (w_last) begin
            r_state    <= S_START;
            eval_start <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_idx    <= r_idx + C_A_ONE;
            r_state  <= S_WAIT_NODE;
            nd_ready <= 1'b1;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_cnt <= w_cnt_next;
          // A result arriving on the expiry cycle still counts as success
          if (exp_change) begin
            r_state     <= S_RESULT;
            res_valid   <= 1'b1;
            res_exp     <= exp;
            res_act     <= act;
            res_timeout <= 1'b0;
          end else if (w_cnt_next == C_CNT_LAST) begin
            r_state     <= S_RESULT;
            res_valid   <= 1'b1;
            res_exp     <= exp;
            res_act     <= act;
            res_timeout <= 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_state   <= S_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          nd_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tree_loader.sv
// tb/tb_tree_loader.sv - Scoreboard bench for tree_loader load, evaluate, timeout and reset behaviour
`timescale 1ns/1ps
module tb_tree_loader;

  localparam int TO = 64;
  localparam int K_CONF = 0, K_PAR = 1, K_REW = 2, K_ACT = 3, K_WGT = 4, K_EST = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready;
  logic [9:0] cfg_count;
  logic       nd_valid, nd_ready;
  logic [9:0] nd_parent, nd_reward, nd_weight;
  logic       nd_strat;
  logic [2:0] nd_action;
  logic       conf_nodes;
  logic [9:0] conf_data;
  logic       mem_par, mem_rew, mem_act, mem_weight;
  logic [9:0] mem_addr, mem_data;
  logic       eval_start;
  logic       exp_change;
  logic [9:0] exp;
  logic [2:0] act;
  logic       res_valid, res_ready, res_timeout;
  logic [9:0] res_exp;
  logic [2:0] res_act;
  logic       busy;

  always #5 clk = ~clk;

  tree_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_count(cfg_count),
    .nd_valid(nd_valid), .nd_ready(nd_ready), .nd_parent(nd_parent), .nd_reward(nd_reward),
    .nd_strat(nd_strat), .nd_action(nd_action), .nd_weight(nd_weight),
    .conf_nodes(conf_nodes), .conf_data(conf_data),
    .mem_par(mem_par), .mem_rew(mem_rew), .mem_act(mem_act), .mem_weight(mem_weight),
    .mem_addr(mem_addr), .mem_data(mem_data), .eval_start(eval_start),
    .exp_change(exp_change), .exp(exp), .act(act),
    .res_valid(res_valid), .res_ready(res_ready), .res_exp(res_exp), .res_act(res_act),
    .res_timeout(res_timeout), .busy(busy)
  );

  typedef struct { int kind; int addr; int data; } stb_t;
  typedef struct { int ex; int ac; int to; } res_t;
  stb_t stb_q[$];
  res_t res_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_mem = 0;
  int n_par0 = 0;
  int n_estart = 0;
  int eval_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Write-strobe monitor: one strobe per cycle, idle bus zero, each strobe matched in order
  initial begin : strobe_mon
    int hot, kind, a, d;
    stb_t e;
    forever begin
      @(negedge clk);
      hot = int'(conf_nodes) + int'(mem_par) + int'(mem_rew) + int'(mem_act) + int'(mem_weight) + int'(eval_start);
      check("strobe_onehot", int'(hot <= 1), 1);
      if (hot == 0) begin
        check("idle_bus", int'(mem_addr) + int'(mem_data), 0);
      end else if (hot == 1) begin
        kind = conf_nodes ? K_CONF : mem_par ? K_PAR : mem_rew ? K_REW :
               mem_act ? K_ACT : mem_weight ? K_WGT : K_EST;
        a = int'(mem_addr);
        d = (kind == K_CONF) ? int'(conf_data) : int'(mem_data);
        if (kind >= K_PAR && kind <= K_WGT) n_mem++;
        if (kind == K_PAR && a == 0) n_par0++;
        if (kind == K_EST) n_estart++;
        if (stb_q.size() == 0) begin
          check("unexpected_strobe_kind", kind, -1);
        end else begin
          e = stb_q.pop_front();
          check("strobe_kind", kind, e.kind);
          check("strobe_addr", a, e.addr);
          check("strobe_data", d, e.data);
        end
      end
    end
  end

  // Result monitor: compare on presentation, then require stability while held
  initial begin : res_mon
    logic       pv;
    logic [9:0] pe;
    logic [2:0] pa;
    logic       pt;
    res_t       r;
    pv = 1'b0; pe = '0; pa = '0; pt = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid && !pv) begin
        if (res_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          r = res_q.pop_front();
          check("res_exp", int'(res_exp), r.ex);
          check("res_act", int'(res_act), r.ac);
          check("res_timeout", int'(res_timeout), r.to);
        end
      end else if (res_valid && pv) begin
        check("res_stable_exp", int'(res_exp), int'(pe));
        check("res_stable_act", int'(res_act), int'(pa));
        check("res_stable_to", int'(res_timeout), int'(pt));
      end
      pv = res_valid; pe = res_exp; pa = res_act; pt = res_timeout;
    end
  end

  // Evaluator model: answers exp=45, act=001 three cycles after eval_start when enabled
  initial begin : evaluator
    forever begin
      @(negedge clk);
      if (eval_start && eval_mode == 0) begin
        repeat (3) @(negedge clk);
        exp = 10'd45; act = 3'b001; exp_change = 1'b1;
        @(negedge clk);
        exp_change = 1'b0;
      end
    end
  end

  task automatic do_cfg(input int c);
    int n;
    if (c != 0) stb_q.push_back('{K_CONF, 0, c});
    cfg_count = 10'(c);
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
    check("cfg_ready_wait", int'(n < 50), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_node(input int i, input int par, input int rew, input int st,
                           input int ac, input int wgt, input int cnt, input int full);
    int n;
    logic [9:0] v;
    v = 10'(rew);
    if (i != 0) stb_q.push_back('{K_PAR, i, par});
    stb_q.push_back('{K_REW, i, int'(v)});
    if (full != 0) begin
      stb_q.push_back('{K_ACT, i, st * 8 + ac});
      stb_q.push_back('{K_WGT, i, wgt});
      if (i == cnt - 1) stb_q.push_back('{K_EST, 0, 0});
    end
    nd_parent = 10'(par); nd_reward = v; nd_strat = st[0];
    nd_action = 3'(ac); nd_weight = 10'(wgt);
    nd_valid = 1'b1;
    n = 0;
    while (!nd_ready && n < 50) begin @(negedge clk); n++; end
    check("nd_ready_wait", int'(n < 50), 1);
    @(negedge clk);
    nd_valid = 1'b0;
  endtask

  task automatic wait_result(input int delta, input int hold);
    int n, t0;
    n = 0;
    while (!eval_start && n < 100) begin @(negedge clk); n++; end
    check("eval_start_seen", int'(n < 100), 1);
    t0 = cyc;
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    check("res_valid_seen", int'(n < 200), 1);
    check("result_latency", cyc - t0, delta);
    repeat (hold) @(negedge clk);
    check("held_res_valid", int'(res_valid), 1);
    check("held_busy", int'(busy), 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_cfg_ready", int'(cfg_ready), 1);
    check("idle_res_valid", int'(res_valid), 0);
  endtask

  int t_par[7] = '{0, 0, 0, 0, 1, 1, 1};
  int t_rew[7] = '{0, 0, -10, 0, 100, -50, 10};
  int t_wgt[7] = '{0, 64, 64, 128, 64, 64, 128};
  int t_st[7]  = '{1, 1, 1, 1, 0, 0, 0};
  int t_ac[7]  = '{0, 1, 2, 3, 1, 0, 1};

  initial begin : stim
    int n;
    rst = 1'b0; cfg_valid = 1'b0; cfg_count = '0; nd_valid = 1'b0;
    nd_parent = '0; nd_reward = '0; nd_strat = 1'b0; nd_action = '0; nd_weight = '0;
    exp_change = 1'b0; exp = '0; act = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_nd_ready", int'(nd_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_outputs", int'(conf_data) + int'(res_exp) + int'(res_act) + int'(res_timeout), 0);
    rst = 1'b1;
    @(negedge clk);

    // Seven-node tree with evaluator answering after three cycles
    eval_mode = 0;
    do_cfg(7);
    for (int i = 0; i < 7; i++) send_node(i, t_par[i], t_rew[i], t_st[i], t_ac[i], t_wgt[i], 7, 1);
    res_q.push_back('{45, 1, 0});
    wait_result(4, 2);
    check("tree7_mem_strobes", n_mem, 27);
    check("tree7_par_addr0", n_par0, 0);
    check("tree7_eval_start", n_estart, 1);

    // Single node, silent evaluator: timeout path with a held result
    eval_mode = 1;
    exp = 10'd17; act = 3'd5;
    exp_change = 1'b1;
    @(negedge clk);
    exp_change = 1'b0;
    check("exp_change_idle_busy", int'(busy), 0);
    do_cfg(1);
    send_node(0, 0, 7, 0, 4, 12, 1, 1);
    res_q.push_back('{17, 5, 1});
    wait_result(TO, 5);

    // Zero count is ignored and node records outside WAIT_NODE do nothing
    do_cfg(0);
    check("zero_cfg_busy", int'(busy), 0);
    check("zero_cfg_ready", int'(cfg_ready), 1);
    nd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_nd_busy", int'(busy), 0);
      check("zero_nd_ready", int'(nd_ready), 0);
    end
    nd_valid = 1'b0;
    @(negedge clk);

    // Reset while node 3 is being written, then a fresh one-node load
    eval_mode = 0;
    do_cfg(7);
    for (int i = 0; i < 3; i++) send_node(i, t_par[i], t_rew[i], t_st[i], t_ac[i], t_wgt[i], 7, 1);
    send_node(3, t_par[3], t_rew[3], t_st[3], t_ac[3], t_wgt[3], 7, 0);
    n = 0;
    while (!mem_rew && n < 20) begin @(negedge clk); n++; end
    check("node3_rew_seen", int'(n < 20), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_strobes", int'(mem_par) + int'(mem_rew) + int'(mem_act) + int'(mem_weight) +
          int'(conf_nodes) + int'(eval_start), 0);
    check("async_rst_cfg_ready", int'(cfg_ready), 1);
    check("async_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_cfg_ready", int'(cfg_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_queue", stb_q.size(), 0);
    do_cfg(1);
    send_node(0, 0, -3, 1, 6, 33, 1, 1);
    res_q.push_back('{45, 1, 0});
    wait_result(4, 0);

    repeat (5) @(negedge clk);
    check("final_strobe_queue", stb_q.size(), 0);
    check("final_result_queue", res_q.size(), 0);
    check("final_eval_starts", n_estart, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
